multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port iReset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port iOpcode, input, 11 bits: instruction bits [31:21], taken from the datapath instruction register.
REQ-004 SHALL have port iZero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have port iMemReady, input, 1 bit: memory access complete, sampled in FETCH and MEM.
REQ-006 SHALL have outputs oPCWrite, oIRWrite, oReg2Loc, oALUSrc, oMemtoReg, oRegWrite, oMemRead, oMemWrite and oBranch, 1 bit each: datapath control strobes and selects.
REQ-007 SHALL have outputs oOrigemPC and oALUOp, 2 bits each: next-PC select (00 PC+4, 01 branch target, 10 jump target) and ALU operation class.
REQ-008 SHALL have outputs oState (3 bits), oIllegal (1 bit) and oRetired (32 bits): current state, halt flag and retired-instruction count.

Function
REQ-009 SHALL use state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-010 SHALL, in FETCH, hold oMemRead=1; SHALL stay in FETCH while iMemReady=0; SHALL pulse oIRWrite=1 and move to DECODE in the cycle iMemReady=1.
REQ-011 SHALL, in DECODE, latch an instruction class into an internal register:
- R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000)
- LD (11111000010), ST (11111000000)
- CBZ (10110100xxx), B (000101xxxxx)
REQ-012 SHALL, in DECODE, move to EXEC for any recognised class; otherwise move to HALT.
REQ-013 SHALL, in EXEC for class R, drive oALUOp=10 and oALUSrc=0, then go to WB.
REQ-014 SHALL, in EXEC for class LD or ST, drive oALUOp=00 and oALUSrc=1, then go to MEM.
REQ-015 SHALL, in EXEC for class CBZ, drive oALUOp=01, oReg2Loc=1, oBranch=1 and oPCWrite=1, with oOrigemPC=01 if iZero=1 else 00; next state FETCH.
REQ-016 SHALL, in EXEC for class B, drive oPCWrite=1 and oOrigemPC=10; next state FETCH.
REQ-017 SHALL, in MEM for LD, hold oMemRead=1 until iMemReady=1, then go to WB.
REQ-018 SHALL, in MEM for ST, hold oMemWrite=1 and oReg2Loc=1 until iMemReady=1; in that cycle SHALL drive oPCWrite=1 and oOrigemPC=00, then go to FETCH.
REQ-019 SHALL, in WB, drive oRegWrite=1, oMemtoReg=1 for LD and 0 for R, oPCWrite=1 and oOrigemPC=00; next state FETCH.
REQ-020 SHALL keep ALU selects (oALUOp, oALUSrc) stable through MEM and WB at their EXEC values, for class LD/ST in MEM and class R/LD in WB.
REQ-021 SHALL drive every strobe not named for the current state to 0; oPCWrite, oRegWrite and oMemWrite SHALL never be 1 in FETCH or DECODE.
REQ-022 SHALL increment oRetired by 1 on each cycle with oPCWrite=1, wrapping 0xFFFFFFFF to 0.
REQ-023 SHALL, in HALT, hold oIllegal=1 and all strobes at 0, and stay in HALT until reset.
REQ-024 SHALL give these latencies at iMemReady=1 with no wait: R 4 cycles, LD 5, ST 4, CBZ 3, B 3.

Reset
REQ-025 SHALL, on iReset=0, immediately and without waiting for a clock edge, force state FETCH, oRetired=0, oIllegal=0, the class register to R, and every strobe to 0 except oMemRead=1 (FETCH behaviour).
REQ-026 SHALL, when reset is asserted mid-access (MEM with oMemWrite=1), drop oMemWrite in the same cycle; the partial instruction is not retired.
REQ-027 SHALL leave FETCH on the first rising edge after iReset returns to 1, if iMemReady=1.

Configuration
REQ-028 SHALL support macro CBNZ_EN: when defined, opcode 10110101xxx decodes as class CBNZ, handled like CBZ but with oOrigemPC=01 when iZero=0 and 00 when iZero=1.
REQ-029 SHALL, without CBNZ_EN, treat opcode 10110101xxx as illegal and go to HALT.

Verification
REQ-030 Bench SHALL run ADD (10001011000) with iMemReady=1 -> states 0,1,2,4,0; oRegWrite=1 and oPCWrite=1 at WB only; oRetired=1.
REQ-031 Bench SHALL run LDUR with iMemReady held 0 for 3 cycles in MEM -> MEM lasts 4 cycles with oMemRead=1; WB has oMemtoReg=1; total 8 cycles.
REQ-032 Bench SHALL run CBZ with iZero=1, then with iZero=0 -> EXEC gives oOrigemPC=01, then 00; both take 3 cycles.
REQ-033 Bench SHALL run opcode 11111111111 -> HALT, oIllegal=1, strobes 0 for 20 cycles; iReset=0 then returns to FETCH and oIllegal=0.
REQ-034 Bench SHALL run opcode 10110101000 with iZero=0 -> with CBNZ_EN, oOrigemPC=01 in EXEC; without it, HALT.
REQ-035 Bench SHALL preload the count at 0xFFFFFFFF and retire B -> oRetired=0; async reset during STUR MEM -> oMemWrite=0 before the next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Control unit for a multicycle LEGv8 datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional macro CBNZ_EN adds the CBNZ class (opcode 10110101xxx); without it that opcode halts.
module multicycle_control (
  input  logic        iCLK,
  input  logic        iReset,
  input  logic [10:0] iOpcode,
  input  logic        iZero,
  input  logic        iMemReady,
  output logic        oPCWrite,
  output logic        oIRWrite,
  output logic        oReg2Loc,
  output logic        oALUSrc,
  output logic        oMemtoReg,
  output logic        oRegWrite,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oBranch,
  output logic [1:0]  oOrigemPC,
  output logic [1:0]  oALUOp,
  output logic [2:0]  oState,
  output logic        oIllegal,
  output logic [31:0] oRetired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LD   = 3'd1,
    C_ST   = 3'd2,
    C_CBZ  = 3'd3,
    C_B    = 3'd4,
    C_CBNZ = 3'd5
  } cls_t;

  state_t state;
  cls_t   cls;
  cls_t   dec_cls;
  logic   dec_ok;

  assign oState = 3'(state);

  // Opcode classification; only consumed in DECODE.
  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_R;
    casez (iOpcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_cls = C_R;
      11'b11111000010: dec_cls = C_LD;
      11'b11111000000: dec_cls = C_ST;
      11'b10110100???: dec_cls = C_CBZ;
`ifdef CBNZ_EN
      11'b10110101???: dec_cls = C_CBNZ;
`endif
      11'b000101?????: dec_cls = C_B;
      default:         dec_ok  = 1'b0;
    endcase
  end

  // Strobes follow the state register and the same-cycle handshake/zero inputs,
  // so a reset or a memory-ready edge takes effect without an extra cycle.
  always_comb begin
    oPCWrite  = 1'b0;
    oIRWrite  = 1'b0;
    oReg2Loc  = 1'b0;
    oALUSrc   = 1'b0;
    oMemtoReg = 1'b0;
    oRegWrite = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oBranch   = 1'b0;
    oOrigemPC = 2'b00;
    oALUOp    = 2'b00;
    case (state)
      S_FETCH: begin
        oMemRead = 1'b1;
        oIRWrite = iMemReady;
      end
      S_EXEC: begin
        case (cls)
          C_R: oALUOp = 2'b10;
          C_LD, C_ST: oALUSrc = 1'b1;
          C_CBZ, C_CBNZ: begin
            oALUOp    = 2'b01;
            oReg2Loc  = 1'b1;
            oBranch   = 1'b1;
            oPCWrite  = 1'b1;
            oOrigemPC = {1'b0, (cls == C_CBZ) ? iZero : ~iZero};
          end
          C_B: begin
            oPCWrite  = 1'b1;
            oOrigemPC = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        oALUSrc = 1'b1;
        if (cls == C_LD) begin
          oMemRead = 1'b1;
        end else begin
          oMemWrite = 1'b1;
          oReg2Loc  = 1'b1;
          oPCWrite  = iMemReady;
        end
      end
      S_WB: begin
        oRegWrite = 1'b1;
        oPCWrite  = 1'b1;
        oMemtoReg = (cls == C_LD);
        oALUSrc   = (cls == C_LD);
        oALUOp    = (cls == C_R) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // Sequencing, class latch, halt flag and retire counter.
  always_ff @(posedge iCLK or negedge iReset) begin
    if (!iReset) begin
      state    <= S_FETCH;
      cls      <= C_R;
      oIllegal <= 1'b0;
      oRetired <= 32'd0;
    end else begin
      if (oPCWrite) oRetired <= oRetired + 32'd1;
      case (state)
        S_FETCH: if (iMemReady) state <= S_DECODE;
        S_DECODE: begin
          if (dec_ok) begin
            cls   <= dec_cls;
            state <= S_EXEC;
          end else begin
            state    <= S_HALT;
            oIllegal <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cls)
            C_R:        state <= S_WB;
            C_LD, C_ST: state <= S_MEM;
            default:    state <= S_FETCH;
          endcase
        end
        S_MEM: if (iMemReady) state <= (cls == C_LD) ? S_WB : S_FETCH;
        S_WB:   state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: begin
          state    <= S_HALT;
          oIllegal <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: latency table, directed corner cases and a
// randomized run against a per-phase instruction model. Honours CBNZ_EN.
module tb_multicycle_control;

  logic        iCLK = 1'b0;
  logic        iReset;
  logic [10:0] iOpcode;
  logic        iZero;
  logic        iMemReady;
  logic        oPCWrite, oIRWrite, oReg2Loc, oALUSrc, oMemtoReg;
  logic        oRegWrite, oMemRead, oMemWrite, oBranch;
  logic [1:0]  oOrigemPC, oALUOp;
  logic [2:0]  oState;
  logic        oIllegal;
  logic [31:0] oRetired;

  multicycle_control dut (
    .iCLK(iCLK), .iReset(iReset), .iOpcode(iOpcode), .iZero(iZero),
    .iMemReady(iMemReady), .oPCWrite(oPCWrite), .oIRWrite(oIRWrite),
    .oReg2Loc(oReg2Loc), .oALUSrc(oALUSrc), .oMemtoReg(oMemtoReg),
    .oRegWrite(oRegWrite), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oBranch(oBranch), .oOrigemPC(oOrigemPC), .oALUOp(oALUOp),
    .oState(oState), .oIllegal(oIllegal), .oRetired(oRetired)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [2:0] state;
    logic       illegal;
    logic       pcw, irw, r2l, alusrc, m2r, rw, mr, mw, br;
    logic [1:0] org, aluop;
  } ctl_t;

  typedef struct {
    logic [10:0] opc;
    logic        z;
    int          lat;
    logic [1:0]  org;
  } vec_t;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_CBNZ = 5, K_ILL = 6;

  ctl_t        act;
  int          errs = 0;
  int          checks = 0;
  int          ncyc;
  logic [31:0] model_ret;
  logic        rand_dc;

  always_comb act = '{state: oState, illegal: oIllegal, pcw: oPCWrite, irw: oIRWrite,
                      r2l: oReg2Loc, alusrc: oALUSrc, m2r: oMemtoReg, rw: oRegWrite,
                      mr: oMemRead, mw: oMemWrite, br: oBranch, org: oOrigemPC,
                      aluop: oALUOp};

  function automatic int classify(input logic [10:0] o);
    logic [7:0] hi8;
    logic [5:0] hi6;
    hi8 = o[10:3];
    hi6 = o[10:5];
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return K_R;
    if (o == 11'b11111000010) return K_LD;
    if (o == 11'b11111000000) return K_ST;
    if (hi8 == 8'b10110100) return K_CBZ;
    if (hi8 == 8'b10110101) begin
`ifdef CBNZ_EN
      return K_CBNZ;
`else
      return K_ILL;
`endif
    end
    if (hi6 == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  // Expected strobes per phase, straight from the per-state rules.
  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e = '0;
    e.mr = 1'b1; e.irw = rdy;
    return e;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t e = '0;
    e.state = 3'd1;
    return e;
  endfunction

  function automatic ctl_t e_exec(input int k, input logic z);
    ctl_t e = '0;
    e.state = 3'd2;
    if (k == K_R) e.aluop = 2'b10;
    if (k == K_LD || k == K_ST) e.alusrc = 1'b1;
    if (k == K_CBZ || k == K_CBNZ) begin
      e.aluop = 2'b01; e.r2l = 1'b1; e.br = 1'b1; e.pcw = 1'b1;
      e.org = ((k == K_CBZ) == z) ? 2'b01 : 2'b00;
    end
    if (k == K_B) begin e.pcw = 1'b1; e.org = 2'b10; end
    return e;
  endfunction

  function automatic ctl_t e_mem(input int k, input logic rdy);
    ctl_t e = '0;
    e.state = 3'd3; e.alusrc = 1'b1;
    if (k == K_LD) e.mr = 1'b1;
    else begin e.mw = 1'b1; e.r2l = 1'b1; e.pcw = rdy; end
    return e;
  endfunction

  function automatic ctl_t e_wb(input int k);
    ctl_t e = '0;
    e.state = 3'd4; e.rw = 1'b1; e.pcw = 1'b1;
    e.m2r = (k == K_LD); e.alusrc = (k == K_LD);
    e.aluop = (k == K_R) ? 2'b10 : 2'b00;
    return e;
  endfunction

  function automatic ctl_t e_halt();
    ctl_t e = '0;
    e.state = 3'd7; e.illegal = 1'b1;
    return e;
  endfunction

  function automatic logic dc();
    return rand_dc ? 1'($urandom) : 1'b1;
  endfunction

  task automatic check_ctl(input string nm, input ctl_t e);
    checks++;
    if (act !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h (state %0d want %0d) t=%0t", nm, act, e, act.state, e.state, $time);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h t=%0t", nm, got, want, $time);
    end
  endtask

  // One clock of lock-step: drive, compare, clock, advance model counter.
  task automatic chk(input string nm, input ctl_t e, input logic rdy, input logic z);
    iMemReady = rdy; iZero = z;
    #1;
    check_ctl(nm, e);
    check_val({nm, " retired"}, oRetired, model_ret);
    @(posedge iCLK);
    if (e.pcw) model_ret = model_ret + 32'd1;
    @(negedge iCLK);
    ncyc++;
  endtask

  task automatic run_instr(input logic [10:0] opc, input int fw, input int mw,
                           input logic z, output int cyc);
    int k;
    k = classify(opc);
    ncyc = 0;
    iOpcode = opc;
    for (int i = 0; i < fw; i++) chk("fetch_wait", e_fetch(1'b0), 1'b0, dc());
    chk("fetch", e_fetch(1'b1), 1'b1, dc());
    chk("decode", e_decode(), dc(), dc());
    if (k != K_ILL) begin
      chk("exec", e_exec(k, z), dc(), z);
      if (k == K_LD || k == K_ST) begin
        for (int i = 0; i < mw; i++) chk("mem_wait", e_mem(k, 1'b0), 1'b0, dc());
        chk("mem", e_mem(k, 1'b1), 1'b1, dc());
      end
      if (k == K_R || k == K_LD) chk("wb", e_wb(k), dc(), dc());
    end
    cyc = ncyc;
  endtask

  // Async reset mid-cycle; outputs must reflect FETCH before any edge.
  task automatic reset_dut(input string nm);
    iMemReady = 1'b0;
    #2 iReset = 1'b0;
    #1;
    check_ctl({nm, " reset"}, e_fetch(1'b0));
    check_val({nm, " reset retired"}, oRetired, 32'd0);
    @(negedge iCLK);
    iReset = 1'b1;
    model_ret = 32'd0;
  endtask

  vec_t tbl[9];

  initial begin
    int cyc, cnt, kind;
    logic [1:0] exo;
    logic [10:0] opc;
    logic [10:0] rops[4];

    tbl[0] = '{11'b10001011000, 1'b0, 4, 2'b00};
    tbl[1] = '{11'b11001011000, 1'b1, 4, 2'b00};
    tbl[2] = '{11'b10001010000, 1'b0, 4, 2'b00};
    tbl[3] = '{11'b10101010000, 1'b0, 4, 2'b00};
    tbl[4] = '{11'b11111000010, 1'b0, 5, 2'b00};
    tbl[5] = '{11'b11111000000, 1'b1, 4, 2'b00};
    tbl[6] = '{11'b10110100101, 1'b1, 3, 2'b01};
    tbl[7] = '{11'b10110100000, 1'b0, 3, 2'b00};
    tbl[8] = '{11'b00010111111, 1'b0, 3, 2'b10};
    rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

    rand_dc = 1'b0;
    iReset = 1'b1; iOpcode = '0; iZero = 1'b0; iMemReady = 1'b0; model_ret = '0;
    @(negedge iCLK);
    reset_dut("init");

    // Latency/next-PC table, each instruction from a fresh reset.
    for (int v = 0; v < 9; v++) begin
      reset_dut("tbl");
      iOpcode = tbl[v].opc; iZero = tbl[v].z; iMemReady = 1'b1;
      cnt = 0; exo = 2'b11;
      for (int c = 0; c < 20; c++) begin
        #1 if (oState == 3'd2) exo = oOrigemPC;
        @(posedge iCLK);
        @(negedge iCLK);
        cnt++;
        if (oState == 3'd0) break;
      end
      check_val($sformatf("tbl%0d latency", v), 32'(cnt), 32'(tbl[v].lat));
      check_val($sformatf("tbl%0d exec_org", v), 32'(exo), 32'(tbl[v].org));
      check_val($sformatf("tbl%0d retired", v), oRetired, 32'd1);
    end

    // ADD from reset, then LDUR with a slow memory.
    reset_dut("add");
    run_instr(11'b10001011000, 0, 0, 1'b0, cyc);
    check_val("add cycles", 32'(cyc), 32'd4);
    check_val("add retired", oRetired, 32'd1);
    run_instr(11'b11111000010, 0, 3, 1'b0, cyc);
    check_val("ldur cycles", 32'(cyc), 32'd8);

    run_instr(11'b10110100000, 0, 0, 1'b1, cyc);
    check_val("cbz z1 cycles", 32'(cyc), 32'd3);
    run_instr(11'b10110100000, 0, 0, 1'b0, cyc);
    check_val("cbz z0 cycles", 32'(cyc), 32'd3);

    // Illegal opcode halts until reset.
    run_instr(11'b11111111111, 0, 0, 1'b0, cyc);
    for (int i = 0; i < 20; i++) chk("halt", e_halt(), 1'($urandom), 1'($urandom));
    reset_dut("halt");

    // CBNZ opcode: branch class with CBNZ_EN, halt otherwise.
    run_instr(11'b10110101000, 0, 0, 1'b0, cyc);
    if (classify(11'b10110101000) == K_ILL) begin
      for (int i = 0; i < 3; i++) chk("cbnz_halt", e_halt(), 1'b1, 1'b0);
    end
    reset_dut("cbnz");

    // Retire counter wrap.
    force dut.oRetired = 32'hFFFF_FFFF;
    #1 release dut.oRetired;
    model_ret = 32'hFFFF_FFFF;
    check_val("preload", oRetired, 32'hFFFF_FFFF);
    @(negedge iCLK);
    run_instr(11'b00010100000, 0, 0, 1'b0, cyc);
    check_val("wrap", oRetired, 32'd0);

    // Reset during a store's memory phase.
    reset_dut("stur");
    iOpcode = 11'b11111000000;
    chk("st fetch", e_fetch(1'b1), 1'b1, 1'b0);
    chk("st decode", e_decode(), 1'b1, 1'b0);
    chk("st exec", e_exec(K_ST, 1'b0), 1'b0, 1'b0);
    iMemReady = 1'b0;
    #1 check_ctl("st mem", e_mem(K_ST, 1'b0));
    #2 iReset = 1'b0;
    #1 check_ctl("st abort", e_fetch(1'b0));
    check_val("st abort retired", oRetired, 32'd0);
    @(negedge iCLK);
    iReset = 1'b1;
    model_ret = 32'd0;

    // Randomized instruction stream with random memory stalls.
    rand_dc = 1'b1;
    for (int n = 0; n < 300; n++) begin
`ifdef CBNZ_EN
      kind = $urandom_range(0, 5);
`else
      kind = $urandom_range(0, 4);
`endif
      case (kind)
        0: opc = rops[$urandom_range(0, 3)];
        1: opc = 11'b11111000010;
        2: opc = 11'b11111000000;
        3: opc = {8'b10110100, 3'($urandom)};
        4: opc = {6'b000101, 5'($urandom)};
        default: opc = {8'b10110101, 3'($urandom)};
      endcase
      run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), cyc);
    end
    check_val("final retired", oRetired, model_ret);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
    $fatal(1);
  end

endmodule
